// File: rtl/divu_pkg.sv
// Shared types and constants for the sequential unsigned divider (DIVU path).
package divu_pkg;

    localparam int unsigned DIVU_WIDTH = 32;

    // Quotient produced by a zero-divisor op: every restoring step succeeds.
    localparam logic [DIVU_WIDTH-1:0] DIVU_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } divu_state_e;

endpackage

// File: rtl/divu_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module divu_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] prem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {prem_i, dvd_msb_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        // The true difference always fits in WIDTH bits, so a WIDTH-bit subtract is exact.
        prem_o  = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divu_seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIVU_EARLY_OUT_EN: finish immediately when dividend < divisor.
module divu_seq_divider
    import divu_pkg::*;
#(
    parameter  int unsigned WIDTH = DIVU_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    divu_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH-1:0] prem_d;
    logic             qbit;

    divu_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prem_i   (prem_q),
        .dvd_msb_i(dvd_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .prem_o   (prem_d),
        .qbit_o   (qbit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
`ifdef DIVU_EARLY_OUT_EN
                        if (dividend_i < divisor_i) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '0;
                            rem_q   <= dividend_i;
                            dbz_q   <= 1'b0;
                        end else
`endif
                        begin
                            dvd_q   <= dividend_i;
                            dvs_q   <= divisor_i;
                            prem_q  <= '0;
                            cnt_q   <= CNT_W'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    prem_q <= prem_d;
                    dvd_q  <= {dvd_q[WIDTH-2:0], qbit};
                    cnt_q  <= cnt_q - CNT_W'(1);
                    // Last step: publish results straight from the step outputs.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= {dvd_q[WIDTH-2:0], qbit};
                        rem_q   <= prem_d;
                        dbz_q   <= (dvs_q == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divu_seq_divider.sv
// Directed self-checking bench for divu_seq_divider (WIDTH = 32).
module tb_divu_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    divu_seq_divider dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; k counts negedges after the accepting posedge (done expected at 33).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_at);
        start       = 1'b1;
        dividend    = a;
        divisor     = b;
        busy_cycles = 0;
        done_at     = -1;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                dividend = 32'hA5A5_5A5A;
                divisor  = 32'h0000_0003;
            end
            if (busy) busy_cycles++;
            if (done) done_at = k;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quot got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_rem got %h want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bc, da;
        run_op(32'd100, 32'd7, bc, da);
        n_cmp++; if (da !== 33) begin n_fail++; $display("FAIL basic_latency got %0d want 33", da); end
        n_cmp++; if (bc !== 32) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 32", bc); end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_quot got %0d want 14", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_rem got %0d want 2", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_hold got %0d want 14", quotient); end
    endtask

    task automatic test_extremes();
        int bc, da;
        run_op(32'hFFFF_FFFF, 32'd1, bc, da);
        n_cmp++; if (da !== 33) begin n_fail++; $display("FAIL max_div1_latency got %0d want 33", da); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL max_div1_quot got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL max_div1_rem got %h want 0", remainder); end
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, da);
        n_cmp++; if (quotient !== 32'd1) begin n_fail++; $display("FAIL max_divmax_quot got %h want 1", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL max_divmax_rem got %h want 0", remainder); end
    endtask

    task automatic test_div_zero();
        int bc, da;
        run_op(32'd5, 32'd0, bc, da);
        n_cmp++; if (da !== 33) begin n_fail++; $display("FAIL dz_latency got %0d want 33", da); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL dz_rem got %0d want 5", remainder); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        @(negedge clk);
        run_op(32'd9, 32'd3, bc, da);
        n_cmp++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL dz_next_quot got %0d want 3", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL dz_next_rem got %0d want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag got %b want 0", div_by_zero); end
    endtask

    task automatic test_start_while_busy();
        int n_done = 0;
        int da     = -1;
        logic [31:0] q_at = '0;
        logic [31:0] r_at = '0;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1 || k == 11) begin
                start    = 1'b0;
                dividend = 32'hDEAD_BEEF;
                divisor  = 32'h0001_2345;
            end
            if (k == 10) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            if (done) begin
                n_done++;
                if (da < 0) begin
                    da   = k;
                    q_at = quotient;
                    r_at = remainder;
                end
            end
        end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count got %0d want 1", n_done); end
        n_cmp++; if (da !== 33) begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 33", da); end
        n_cmp++; if (q_at !== 32'd14) begin n_fail++; $display("FAIL busy_ignore_quot got %0d want 14", q_at); end
        n_cmp++; if (r_at !== 32'd2) begin n_fail++; $display("FAIL busy_ignore_rem got %0d want 2", r_at); end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL busy_ignore_hold got %0d want 14", quotient); end
    endtask

    task automatic test_reset_mid_op();
        int n_done = 0;
        int bc, da;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 15) reset = 1'b1;
            if (k == 16) begin
                reset = 1'b0;
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
                n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL rst_mid_quot got %0d want 0", quotient); end
                n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rem got %0d want 0", remainder); end
            end
            if (done) n_done++;
        end
        n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", n_done); end
        run_op(32'd1000, 32'd3, bc, da);
        n_cmp++; if (quotient !== 32'd333) begin n_fail++; $display("FAIL rst_after_quot got %0d want 333", quotient); end
        n_cmp++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL rst_after_rem got %0d want 1", remainder); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int t1 = -1;
        int t2 = -1;
        int bc = 0;
        logic [31:0] q1 = '0;
        logic [31:0] r1 = '0;
        logic [31:0] q2 = '0;
        logic [31:0] r2 = '0;
`ifdef DIVU_EARLY_OUT_EN
        int exp_t1 = 1;
        int exp_t2 = 34;
        int exp_bc = 32;
`else
        int exp_t1 = 33;
        int exp_t2 = 66;
        int exp_bc = 64;
`endif
        start    = 1'b1;
        dividend = 32'd3;
        divisor  = 32'd10;
        for (int k = 1; k <= 80 && t2 < 0; k++) begin
            @(negedge clk);
            if (k == 1 || k == t1 + 1) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    t1       = k;
                    q1       = quotient;
                    r1       = remainder;
                    start    = 1'b1;
                    dividend = 32'd20;
                    divisor  = 32'd6;
                end else begin
                    t2 = k;
                    q2 = quotient;
                    r2 = remainder;
                end
            end
        end
        n_cmp++; if (t1 !== exp_t1) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", t1, exp_t1); end
        n_cmp++; if (q1 !== 32'd0) begin n_fail++; $display("FAIL b2b_first_quot got %0d want 0", q1); end
        n_cmp++; if (r1 !== 32'd3) begin n_fail++; $display("FAIL b2b_first_rem got %0d want 3", r1); end
        n_cmp++; if (t2 !== exp_t2) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", t2, exp_t2); end
        n_cmp++; if (q2 !== 32'd3) begin n_fail++; $display("FAIL b2b_second_quot got %0d want 3", q2); end
        n_cmp++; if (r2 !== 32'd2) begin n_fail++; $display("FAIL b2b_second_rem got %0d want 2", r2); end
        n_cmp++; if (bc !== exp_bc) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want %0d", bc, exp_bc); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL b2b_dbz got %b want 0", div_by_zero); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
